// File: rtl/outpkt_v2_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// outpkt_v2_rx
// Receiving end of the outpkt_v2 result-packet format. Pulls 16-bit words
// from a first-word-fall-through FIFO, checks the header fields, the length
// and both section checksums, and delivers {pkt_id, word_id, gen_id, result}
// through a one-entry output register.
//
// Packet (16-bit words, low half first):
//   header : {type,version}, 16'h0000, len[15:0], {8'h00,len[23:16]}, pkt_id
//   hcsum  : 2 words, ~sum32(header words)
//   body   : word_id, gen_id lo, gen_id hi, RESULT_LEN/2 result words
//   bcsum  : 2 words, ~sum32(body words)
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   din, empty, rd_en  FIFO read side; a word is taken on a cycle with rd_en=1
//   pkt_id, word_id,
//   gen_id, result     held record (result byte 0 in bits [7:0])
//   out_empty          1 = no record held
//   out_rd_en          downstream takes the held record
//   err_*              sticky error flags, cleared only by reset
//   pkt_count          records delivered, wraps
//   state_dbg          current FSM state (HDR=0 HCSUM=1 BODY=2 BCSUM=3 ERROR=4)
//
// Handshake: the input side transfers a word on every clock edge where
// rd_en=1 (rd_en already includes ~empty). The output side holds a record
// while out_empty=0; the record is taken on an edge where out_rd_en=1 and
// out_empty=0. A record taken and a new one loaded on the same edge leaves
// the new record held.
// ---------------------------------------------------------------------------
module outpkt_v2_rx #(
   parameter int         RESULT_LEN  = 8,
   parameter logic [7:0] PKT_VERSION = 8'h02,
   parameter logic [7:0] PKT_TYPE    = 8'h04
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [15:0]               din,
   input  logic                      empty,
   output logic                      rd_en,
   output logic [15:0]               pkt_id,
   output logic [15:0]               word_id,
   output logic [31:0]               gen_id,
   output logic [8*RESULT_LEN-1:0]   result,
   output logic                      out_empty,
   input  logic                      out_rd_en,
   output logic                      err_version,
   output logic                      err_type,
   output logic                      err_len,
   output logic                      err_checksum,
   output logic [15:0]               pkt_count,
   output logic [2:0]                state_dbg
);

   localparam int          RW         = 8 * RESULT_LEN;
   localparam int          BODY_WORDS = 3 + RESULT_LEN / 2;
   localparam logic [15:0] HDR_LAST   = 16'd4;
   localparam logic [15:0] BODY_LAST  = 16'(BODY_WORDS - 1);
   localparam logic [23:0] EXP_LEN    = 24'(6 + RESULT_LEN);

   // The OUT step of the protocol (copy staging to output, bump count,
   // return to HDR) completes on the same edge that takes the last BCSUM
   // word, so it has no state of its own.
   typedef enum logic [2:0] {
      S_HDR   = 3'd0,
      S_HCSUM = 3'd1,
      S_BODY  = 3'd2,
      S_BCSUM = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t state, state_n;

   logic [15:0]   cnt;        // word index within the current section
   logic [31:0]   sum;        // running section sum
   logic [15:0]   csum_lo;    // first checksum word, held for the 32-bit compare
   logic [7:0]    ver_r;
   logic [7:0]    type_r;
   logic [23:0]   len_r;
   logic [15:0]   pkt_id_s;
   logic [15:0]   word_id_s;
   logic [31:0]   gen_id_s;
   logic [RW-1:0] result_s;

   logic stall;
   logic csum_ok;
   logic ver_ok, type_ok, len_ok;
   logic hcsum_done, bcsum_done, load;

   assign state_dbg = state;

   // ---------------- next state / outputs ----------------
   always_comb begin
      state_n    = state;
      rd_en      = 1'b0;
      // Final checksum word is held back while an untaken record occupies
      // the output register; header and body may still flow.
      stall      = (state == S_BCSUM) && (cnt == 16'd1) && !out_empty && !out_rd_en;
      csum_ok    = ({din, csum_lo} == ~sum);
      ver_ok     = (ver_r == PKT_VERSION);
      type_ok    = (type_r == PKT_TYPE);
      len_ok     = (len_r == EXP_LEN);
      hcsum_done = 1'b0;
      bcsum_done = 1'b0;
      load       = 1'b0;

      case (state)
         S_HDR, S_HCSUM, S_BODY, S_BCSUM: rd_en = ~empty & ~stall;
         default:                         rd_en = 1'b0;
      endcase

      hcsum_done = rd_en && (state == S_HCSUM) && (cnt == 16'd1);
      bcsum_done = rd_en && (state == S_BCSUM) && (cnt == 16'd1);
      load       = bcsum_done && csum_ok;

      case (state)
         S_HDR:   if (rd_en && cnt == HDR_LAST) state_n = S_HCSUM;
         S_HCSUM: if (hcsum_done)
                     state_n = (csum_ok && ver_ok && type_ok && len_ok) ? S_BODY : S_ERROR;
         S_BODY:  if (rd_en && cnt == BODY_LAST) state_n = S_BCSUM;
         S_BCSUM: if (bcsum_done) state_n = csum_ok ? S_HDR : S_ERROR;
         S_ERROR: state_n = S_ERROR;
         default: state_n = S_ERROR;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_HDR;
      else        state <= state_n;
   end

   // ---------------- receive datapath ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt          <= '0;
         sum          <= '0;
         csum_lo      <= '0;
         ver_r        <= '0;
         type_r       <= '0;
         len_r        <= '0;
         pkt_id_s     <= '0;
         word_id_s    <= '0;
         gen_id_s     <= '0;
         result_s     <= '0;
         err_version  <= 1'b0;
         err_type     <= 1'b0;
         err_len      <= 1'b0;
         err_checksum <= 1'b0;
      end else if (rd_en) begin
         case (state)
            S_HDR: begin
               sum <= sum + {16'h0000, din};
               case (cnt)
                  16'd0:   {type_r, ver_r} <= din;
                  16'd2:   len_r[15:0]     <= din;
                  16'd3:   len_r[23:16]    <= din[7:0];
                  16'd4:   pkt_id_s        <= din;
                  default: ;
               endcase
               cnt <= (cnt == HDR_LAST) ? 16'd0 : cnt + 16'd1;
            end
            S_HCSUM: begin
               if (cnt == 16'd0) begin
                  csum_lo <= din;
                  cnt     <= 16'd1;
               end else begin
                  cnt <= 16'd0;
                  sum <= '0;
                  if (!csum_ok) err_checksum <= 1'b1;
                  if (!ver_ok)  err_version  <= 1'b1;
                  if (!type_ok) err_type     <= 1'b1;
                  if (!len_ok)  err_len      <= 1'b1;
               end
            end
            S_BODY: begin
               sum <= sum + {16'h0000, din};
               case (cnt)
                  16'd0:   word_id_s       <= din;
                  16'd1:   gen_id_s[15:0]  <= din;
                  16'd2:   gen_id_s[31:16] <= din;
                  // Result words arrive lowest first; shifting in from the
                  // top leaves word 0 in bits [15:0] after the last one.
                  default: result_s <= RW'({din, result_s} >> 16);
               endcase
               cnt <= (cnt == BODY_LAST) ? 16'd0 : cnt + 16'd1;
            end
            S_BCSUM: begin
               if (cnt == 16'd0) begin
                  csum_lo <= din;
                  cnt     <= 16'd1;
               end else begin
                  cnt <= 16'd0;
                  sum <= '0;
                  if (!csum_ok) err_checksum <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- output register ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_empty <= 1'b1;
         pkt_count <= '0;
         pkt_id    <= '0;
         word_id   <= '0;
         gen_id    <= '0;
         result    <= '0;
      end else if (load) begin
         out_empty <= 1'b0;
         pkt_count <= pkt_count + 16'd1;
         pkt_id    <= pkt_id_s;
         word_id   <= word_id_s;
         gen_id    <= gen_id_s;
         result    <= result_s;
      end else if (out_rd_en && !out_empty) begin
         out_empty <= 1'b1;
      end
   end

endmodule

// File: tb/tb_outpkt_v2_rx.sv
`timescale 1ns/1ps
// Directed bench for outpkt_v2_rx with RESULT_LEN=8. A FIFO model feeds
// words from src_q; each scenario task drives and checks its own results.
module tb_outpkt_v2_rx;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [15:0]  din = 16'h0;
  logic         empty = 1'b1;
  logic         rd_en;
  logic [15:0]  pkt_id, word_id, pkt_count;
  logic [31:0]  gen_id;
  logic [63:0]  result;
  logic         out_empty;
  logic         out_rd_en = 1'b0;
  logic         err_version, err_type, err_len, err_checksum;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  outpkt_v2_rx #(.RESULT_LEN(8), .PKT_VERSION(8'h02), .PKT_TYPE(8'h04)) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .empty(empty), .rd_en(rd_en),
    .pkt_id(pkt_id), .word_id(word_id), .gen_id(gen_id), .result(result),
    .out_empty(out_empty), .out_rd_en(out_rd_en),
    .err_version(err_version), .err_type(err_type), .err_len(err_len),
    .err_checksum(err_checksum), .pkt_count(pkt_count), .state_dbg(state_dbg)
  );

  // ---------------- stimulus data ----------------
  logic [15:0] good_pkt [16] = '{
    16'h0402, 16'h0000, 16'h000E, 16'h0000, 16'h1234,
    16'hE9BB, 16'hFFFF,
    16'h0001, 16'hCDEF, 16'h89AB, 16'h6170, 16'h7373, 16'h6F77, 16'h6472,
    16'hFF98, 16'hFFFC};

  // {pkt_id, word_id, gen_id, result}; result "password", byte0 = 'p'
  localparam logic [127:0] EXP_REC = {16'h1234, 16'h0001, 32'h89ABCDEF, 64'h6472_6F77_7373_6170};

  // ---------------- FIFO model ----------------
  logic [15:0] src_q[$];
  int bubble_pct = 0;
  bit took = 1'b0;
  int last_cyc = 0;   // clock edge on which the last queued word was taken

  initial forever begin
    @(negedge CLK);
    if (took && src_q.size() > 0) void'(src_q.pop_front());
    took = 1'b0;
    if (src_q.size() > 0 && !($urandom_range(0, 99) < bubble_pct)) begin
      din = src_q[0];
      empty = 1'b0;
    end else begin
      din = 16'h0;
      empty = 1'b1;
    end
    #2;
    took = rd_en && !empty && RST_N;
    if (took && src_q.size() == 1) last_cyc = cyc + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
    #3;
  endtask

  task automatic push_pkt(input int bad_idx, input logic [15:0] bad_val);
    for (int i = 0; i < 16; i++) src_q.push_back((i == bad_idx) ? bad_val : good_pkt[i]);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    src_q.delete();
    took = 1'b0;
    out_rd_en = 1'b0;
    bubble_pct = 0;
    repeat (2) tick();
    @(negedge CLK);
    RST_N = 1'b1;
    #3;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    src_q.delete();
    took = 1'b0;
    out_rd_en = 1'b0;
    repeat (2) tick();
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_out_empty: got %b expected 1", out_empty); end
    checks++; if ({err_version, err_type, err_len, err_checksum} !== 4'b0000) begin errors++; $display("FAIL reset_errs: got %b expected 0000", {err_version, err_type, err_len, err_checksum}); end
    checks++; if (pkt_count !== 16'h0) begin errors++; $display("FAIL reset_pkt_count: got %h expected 0000", pkt_count); end
    checks++; if ({pkt_id, word_id, gen_id, result} !== 128'h0) begin errors++; $display("FAIL reset_record: got %h expected 0", {pkt_id, word_id, gen_id, result}); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_idle: got %b expected 0", rd_en); end
    @(negedge CLK);
    RST_N = 1'b1;
    #3;
  endtask

  task automatic test_good();
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(-1, 16'h0);
    for (int i = 0; i < 60 && out_empty; i++) tick();
    checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL good_timeout: got out_empty %b expected 0", out_empty); end
    checks++; if (cyc !== last_cyc) begin errors++; $display("FAIL good_latency: got edge %0d expected edge %0d", cyc, last_cyc); end
    checks++; if ({pkt_id, word_id, gen_id, result} !== EXP_REC) begin errors++; $display("FAIL good_record: got %h expected %h", {pkt_id, word_id, gen_id, result}, EXP_REC); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL good_pkt_count: got %0d expected 1", pkt_count); end
    checks++; if ({err_version, err_type, err_len, err_checksum} !== 4'b0000) begin errors++; $display("FAIL good_errs: got %b expected 0000", {err_version, err_type, err_len, err_checksum}); end
    tick();
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL good_taken: got out_empty %b expected 1", out_empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(-1, 16'h0);
    push_pkt(-1, 16'h0);
    for (int i = 0; i < 100 && pkt_count != 16'd2; i++) tick();
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL b2b_pkt_count: got %0d expected 2", pkt_count); end
    checks++; if ({pkt_id, word_id, gen_id, result} !== EXP_REC) begin errors++; $display("FAIL b2b_record: got %h expected %h", {pkt_id, word_id, gen_id, result}, EXP_REC); end
    checks++; if (src_q.size() !== 0) begin errors++; $display("FAIL b2b_drained: got %0d words left expected 0", src_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rd_en = 1'b0;
    push_pkt(-1, 16'h0);
    push_pkt(-1, 16'h0);
    for (int i = 0; i < 60 && out_empty; i++) tick();
    checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL bp_first_timeout: got out_empty %b expected 0", out_empty); end
    repeat (30) tick();
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL bp_held_count: got %0d expected 1", pkt_count); end
    checks++; if ({pkt_id, word_id, gen_id, result} !== EXP_REC) begin errors++; $display("FAIL bp_held_record: got %h expected %h", {pkt_id, word_id, gen_id, result}, EXP_REC); end
    checks++; if (src_q.size() !== 1) begin errors++; $display("FAIL bp_stall_point: got %0d words left expected 1", src_q.size()); end
    checks++; if (rd_en !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got rd_en %b empty %b expected 0 0", rd_en, empty); end
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL bp_state: got %0d expected 3", state_dbg); end
    @(negedge CLK);
    out_rd_en = 1'b1;
    @(negedge CLK);
    out_rd_en = 1'b0;
    #3;
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL bp_second_count: got %0d expected 2", pkt_count); end
    checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL bp_new_wins: got out_empty %b expected 0", out_empty); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL bp_back_to_hdr: got %0d expected 0", state_dbg); end
    @(negedge CLK);
    out_rd_en = 1'b1;
    @(negedge CLK);
    out_rd_en = 1'b0;
    #3;
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL bp_final_take: got out_empty %b expected 1", out_empty); end
  endtask

  task automatic test_bad_version();
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(0, 16'h0403);
    repeat (20) tick();
    // the version change also breaks the header sum (~0x1645 != FFFFE9BB)
    checks++; if ({err_version, err_type, err_len, err_checksum} !== 4'b1001) begin errors++; $display("FAIL badver_errs: got %b expected 1001", {err_version, err_type, err_len, err_checksum}); end
    checks++; if (out_empty !== 1'b1 || pkt_count !== 16'd0) begin errors++; $display("FAIL badver_no_record: got out_empty %b count %0d expected 1 0", out_empty, pkt_count); end
    checks++; if (src_q.size() !== 9) begin errors++; $display("FAIL badver_consumed: got %0d words left expected 9", src_q.size()); end
    checks++; if (rd_en !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL badver_halt: got rd_en %b empty %b expected 0 0", rd_en, empty); end
    checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL badver_state: got %0d expected 4", state_dbg); end
  endtask

  task automatic test_bad_body();
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(10, 16'h6172);
    repeat (30) tick();
    checks++; if ({err_version, err_type, err_len, err_checksum} !== 4'b0001) begin errors++; $display("FAIL badbody_errs: got %b expected 0001", {err_version, err_type, err_len, err_checksum}); end
    checks++; if (out_empty !== 1'b1 || pkt_count !== 16'd0) begin errors++; $display("FAIL badbody_no_record: got out_empty %b count %0d expected 1 0", out_empty, pkt_count); end
    checks++; if (state_dbg !== 3'd4) begin errors++; $display("FAIL badbody_state: got %0d expected 4", state_dbg); end
    push_pkt(-1, 16'h0);
    repeat (20) tick();
    checks++; if (src_q.size() !== 16) begin errors++; $display("FAIL badbody_halt: got %0d words left expected 16", src_q.size()); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL badbody_rd_en: got %b expected 0", rd_en); end
  endtask

  task automatic test_bubbles();
    do_reset();
    out_rd_en = 1'b1;
    bubble_pct = 40;
    push_pkt(-1, 16'h0);
    for (int i = 0; i < 400 && out_empty; i++) tick();
    bubble_pct = 0;
    checks++; if (out_empty !== 1'b0) begin errors++; $display("FAIL bubble_timeout: got out_empty %b expected 0", out_empty); end
    checks++; if (cyc !== last_cyc) begin errors++; $display("FAIL bubble_latency: got edge %0d expected edge %0d", cyc, last_cyc); end
    checks++; if ({pkt_id, word_id, gen_id, result} !== EXP_REC) begin errors++; $display("FAIL bubble_record: got %h expected %h", {pkt_id, word_id, gen_id, result}, EXP_REC); end
    checks++; if (pkt_count !== 16'd1 || {err_version, err_type, err_len, err_checksum} !== 4'b0000) begin errors++; $display("FAIL bubble_status: got count %0d errs %b expected 1 0000", pkt_count, {err_version, err_type, err_len, err_checksum}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rd_en = 1'b1;
    push_pkt(-1, 16'h0);
    for (int i = 0; i < 60 && src_q.size() > 5; i++) tick();
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL midrst_in_body: got %0d expected 2", state_dbg); end
    @(negedge CLK);
    RST_N = 1'b0;
    src_q.delete();
    took = 1'b0;
    #3;
    checks++; if (state_dbg !== 3'd0 || out_empty !== 1'b1) begin errors++; $display("FAIL midrst_cleared: got state %0d out_empty %b expected 0 1", state_dbg, out_empty); end
    tick();
    @(negedge CLK);
    push_pkt(-1, 16'h0);
    RST_N = 1'b1;
    #3;
    for (int i = 0; i < 60 && out_empty; i++) tick();
    checks++; if ({pkt_id, word_id, gen_id, result} !== EXP_REC) begin errors++; $display("FAIL midrst_record: got %h expected %h", {pkt_id, word_id, gen_id, result}, EXP_REC); end
    checks++; if (pkt_count !== 16'd1 || {err_version, err_type, err_len, err_checksum} !== 4'b0000) begin errors++; $display("FAIL midrst_status: got count %0d errs %b expected 1 0000", pkt_count, {err_version, err_type, err_len, err_checksum}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good();
    test_back_to_back();
    test_backpressure();
    test_bad_version();
    test_bad_body();
    test_bubbles();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outpkt_v2_rx.md
Name: outpkt_v2_rx

Overview:
- Receiving end of the outpkt_v2 result-packet format.
- Consumes the 16-bit packet stream from an output FIFO and checks the header, length and both checksums.
- Reassembles {pkt_id, word_id, gen_id, result} and presents it through a one-entry output register.
- Used in loopback/self-test builds and on the host-side bridge to recover candidate words.

Parameters:
- RESULT_LEN, 8, result field length in bytes; must be even.
- PKT_VERSION, 8'h02, required version byte.
- PKT_TYPE, 8'h04, required type byte.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- din  in  16  packet word from first-word-fall-through FIFO
- empty  in  1  source FIFO has no word
- rd_en  out  1  consume din this cycle
- pkt_id  out  16  packet ID
- word_id  out  16  word ID
- gen_id  out  32  generator ID
- result  out  8*RESULT_LEN  result bytes, byte 0 in bits [7:0]
- out_empty  out  1  no record held
- out_rd_en  in  1  downstream takes record
- err_version  out  1  sticky: version mismatch
- err_type  out  1  sticky: type mismatch
- err_len  out  1  sticky: length mismatch
- err_checksum  out  1  sticky: checksum mismatch
- pkt_count  out  16  records delivered, wraps at 16'hFFFF->0

Behaviour:
- Reset: the following clear asynchronously while RST_N is low, including mid-packet; any partial packet is discarded.
  - State goes to HDR; word counter and running sum clear.
  - out_empty=1; all err_* = 0; pkt_count=0; pkt_id/word_id/gen_id/result=0.
- rd_en = ~empty & (state in HDR, HCSUM, BODY, BCSUM). A word is consumed only on cycles where rd_en=1.
- Packet layout (16-bit words, low half first for multi-word fields):
  - Header, 5 words: {type,version}, 16'h0000, len[15:0], {8'h00,len[23:16]}, pkt_id.
  - HCSUM, 2 words.
  - Body, 3+RESULT_LEN/2 words: word_id, gen_id lo, gen_id hi, result words. Result word k = {byte 2k+1, byte 2k}.
  - BCSUM, 2 words.
- Expected len = 6+RESULT_LEN bytes.
- Checksum = ~(sum mod 2^32 of every 16-bit word in the section, zero-extended). Header and body sums are separate. The running sum restarts at each section start.
- States:
  - HDR: capture fields; after the 5th word go to HCSUM.
  - HCSUM: compare the 2 words with the inverted sum.
    - Version, type and len are checked at end of HCSUM.
    - Any mismatch sets the matching err_* flag(s) and goes to ERROR; otherwise go to BODY.
  - BODY: shift fields into staging registers; after the last word go to BCSUM.
  - BCSUM: on the 2nd word, a match goes to OUT; a mismatch sets err_checksum and goes to ERROR.
  - OUT: staging is copied to the output registers, out_empty=0, pkt_count+1, and the state returns to HDR in the same cycle.
  - ERROR: rd_en=0 forever; leave only by reset.
- Output register: out_empty=0 from the cycle after the last BCSUM word is consumed (latency 1).
  - out_rd_en with out_empty=0 sets out_empty=1 next cycle.
  - out_rd_en while out_empty=1 is ignored.
- Backpressure:
  - Input is stalled before BCSUM's 2nd word if out_empty=0 and out_rd_en=0.
  - The next packet's header and body may be received while a record is held.
  - A record is consumed and a new one loaded in the same cycle: new record wins, out_empty stays 0.
- Bubbles (empty=1) mid-packet are legal; state and counters hold.

Test Plan:
- Good packet, RESULT_LEN=8, fed back-to-back, out_rd_en held 1:
  - Stream: 0402,0000,000E,0000,1234, E9BB,FFFF, 0001,CDEF,89AB,6170,7373,6F77,6472, FF98,FFFC.
  - Required: pkt_id=1234, word_id=0001, gen_id=89ABCDEF, result="password" (byte0=0x70), pkt_count=1.
  - out_empty low exactly 1 cycle after the final word.
- Same packet twice with out_rd_en=0: second packet stalls at the final checksum word (rd_en=0), first record stays stable. Pulse out_rd_en -> second record delivered, pkt_count=2.
- First word 0403: err_version=1 after HCSUM, no record, rd_en stays 0 afterwards.
- Body word 6172 instead of 6170: err_checksum=1, out_empty stays 1, halt.
- Random empty bubbles throughout the first scenario -> identical outputs.
- RST_N low in the middle of the body, then the good packet -> errors 0, pkt_count=1, correct record.
